// File: rtl/comp_selftest_pkg.sv
// comp_selftest_pkg: shared constants for the comparator self-test family.
`default_nettype none

package comp_selftest_pkg;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_CHECK  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int DEFAULT_WIDTH         = 2;
  localparam int DEFAULT_SETTLE_CYCLES = 2;

  // Bit positions of the comparator response in the packed {l,e,g} word.
  localparam int LEG_W     = 3;
  localparam int LEG_L_BIT = 2;
  localparam int LEG_E_BIT = 1;
  localparam int LEG_G_BIT = 0;

  function automatic logic [LEG_W-1:0] leg_pack(input logic l, input logic e, input logic g);
    logic [LEG_W-1:0] v;
    v            = '0;
    v[LEG_L_BIT] = l;
    v[LEG_E_BIT] = e;
    v[LEG_G_BIT] = g;
    return v;
  endfunction

endpackage

`default_nettype wire

// File: rtl/comp_ref_model.sv
// comp_ref_model: combinational behavioural reference producing expected {l,e,g}.
`default_nettype none

module comp_ref_model
  import comp_selftest_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [LEG_W-1:0] leg
);

  always_comb begin
    leg = leg_pack(a < b, a == b, a > b);
  end

endmodule

`default_nettype wire

// File: rtl/comp2_selftest.sv
// comp2_selftest: BIST sequencer that scans every operand pair through a comparator.
// First-failure capture is built only when SELFTEST_FIRST_FAIL_EN is defined.
`default_nettype none

module comp2_selftest
  import comp_selftest_pkg::*;
#(
  parameter int WIDTH         = DEFAULT_WIDTH,
  parameter int SETTLE_CYCLES = DEFAULT_SETTLE_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  output logic [WIDTH-1:0]   a_out,
  output logic [WIDTH-1:0]   b_out,
  input  logic               l_in,
  input  logic               e_in,
  input  logic               g_in,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [2*WIDTH:0]   err_count,
  output logic [2*WIDTH-1:0] first_fail_vec,
  output logic [LEG_W-1:0]   first_fail_leg
);

  localparam int VW = 2 * WIDTH;
  localparam int WW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(SETTLE_CYCLES - 1);

  logic [1:0]       r_state;
  logic [VW-1:0]    r_vec;
  logic [WW-1:0]    r_wait;
  logic [VW:0]      r_err;

  logic [LEG_W-1:0] w_exp;
  logic [LEG_W-1:0] w_leg;
  logic             w_fail;
  logic             w_start_ok;
  logic             w_check;

  comp_ref_model #(
    .WIDTH (WIDTH)
  ) u_ref (
    .a   (r_vec[VW-1:WIDTH]),
    .b   (r_vec[WIDTH-1:0]),
    .leg (w_exp)
  );

  // Comparator outputs share our clock, so they are compared without synchronisation.
  always_comb begin
    w_leg = leg_pack(l_in, e_in, g_in);
  end

  assign w_fail     = (w_leg != w_exp);
  assign w_start_ok = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_check    = (r_state == ST_CHECK);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_vec   <= '0;
      r_wait  <= '0;
      r_err   <= '0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (w_start_ok) begin
            r_state <= ST_SETTLE;
            r_vec   <= '0;
            r_wait  <= '0;
            r_err   <= '0;
          end
        end
        ST_SETTLE: begin
          if (r_wait == WAIT_LAST) begin
            r_state <= ST_CHECK;
            r_wait  <= '0;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        ST_CHECK: begin
          if (w_fail) begin
            r_err <= r_err + (VW+1)'(1);
          end
          if (&r_vec) begin
            r_state <= ST_DONE;
          end else begin
            r_vec   <= r_vec + VW'(1);
            r_state <= ST_SETTLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

`ifdef SELFTEST_FIRST_FAIL_EN
  logic          r_captured;
  logic [VW-1:0] r_ff_vec;
  logic [2:0]    r_ff_leg;

  // Sticky flag keeps the earliest failure of a run; cleared on every new run.
  always_ff @(posedge clk) begin
    if (rst || w_start_ok) begin
      r_captured <= 1'b0;
      r_ff_vec   <= '0;
      r_ff_leg   <= '0;
    end else if (w_check && w_fail && !r_captured) begin
      r_captured <= 1'b1;
      r_ff_vec   <= r_vec;
      r_ff_leg   <= w_leg;
    end
  end

  assign first_fail_vec = r_ff_vec;
  assign first_fail_leg = r_ff_leg;
`else
  assign first_fail_vec = '0;
  assign first_fail_leg = '0;
`endif

  assign a_out     = r_vec[VW-1:WIDTH];
  assign b_out     = r_vec[WIDTH-1:0];
  assign busy      = (r_state == ST_SETTLE) || (r_state == ST_CHECK);
  assign done      = (r_state == ST_DONE);
  assign pass      = done && (r_err == '0);
  assign err_count = r_err;

endmodule

`default_nettype wire

// File: tb/tb_comp2_selftest.sv
// tb_comp2_selftest: directed bench for comp2_selftest with emulated faulty comparators.
`default_nettype none

module tb_comp2_selftest;

`ifdef SELFTEST_FIRST_FAIL_EN
  localparam logic [3:0] EXP_SWAP_VEC2 = 4'b0001;
  localparam logic [5:0] EXP_SWAP_VEC3 = 6'b000001;
  localparam logic [2:0] EXP_SWAP_LEG  = 3'b001;
`else
  localparam logic [3:0] EXP_SWAP_VEC2 = 4'b0000;
  localparam logic [5:0] EXP_SWAP_VEC3 = 6'b000000;
  localparam logic [2:0] EXP_SWAP_LEG  = 3'b000;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // Comparator emulation mode: 0 golden, 1 e stuck at 0, 2 l/g swapped.
  logic [1:0] mode2 = 2'd0;
  logic [1:0] mode3 = 2'd0;

  logic       start2 = 1'b0;
  logic [1:0] a2, b2;
  logic       l2, e2, g2, busy2, done2, pass2;
  logic [4:0] err2;
  logic [3:0] ffv2;
  logic [2:0] ffl2;

  logic       start3 = 1'b0;
  logic [2:0] a3, b3;
  logic       l3, e3, g3, busy3, done3, pass3;
  logic [6:0] err3;
  logic [5:0] ffv3;
  logic [2:0] ffl3;

  int tests  = 0;
  int failed = 0;

  comp2_selftest dut2 (
    .clk(clk), .rst(rst), .start(start2), .a_out(a2), .b_out(b2),
    .l_in(l2), .e_in(e2), .g_in(g2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ffv2), .first_fail_leg(ffl2)
  );

  comp2_selftest #(.WIDTH(3), .SETTLE_CYCLES(1)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .a_out(a3), .b_out(b3),
    .l_in(l3), .e_in(e3), .g_in(g3), .busy(busy3), .done(done3), .pass(pass3),
    .err_count(err3), .first_fail_vec(ffv3), .first_fail_leg(ffl3)
  );

  always_comb begin
    l2 = (a2 < b2);
    e2 = (a2 == b2) && (mode2 != 2'd1);
    g2 = (a2 > b2);
    if (mode2 == 2'd2) begin
      l2 = (a2 > b2);
      g2 = (a2 < b2);
    end
  end

  always_comb begin
    l3 = (a3 < b3);
    e3 = (a3 == b3) && (mode3 != 2'd1);
    g3 = (a3 > b3);
    if (mode3 == 2'd2) begin
      l3 = (a3 > b3);
      g3 = (a3 < b3);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset2(input string tag);
    chk({tag, "_ab"},   {28'd0, a2, b2}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy2}, 32'd0);
    chk({tag, "_done"}, {31'd0, done2}, 32'd0);
    chk({tag, "_pass"}, {31'd0, pass2}, 32'd0);
    chk({tag, "_err"},  {27'd0, err2}, 32'd0);
    chk({tag, "_ffv"},  {28'd0, ffv2}, 32'd0);
    chk({tag, "_ffl"},  {29'd0, ffl2}, 32'd0);
  endtask

  // Start a run on dut2 and count edges after T0 until done is seen.
  task automatic run2(input int pulse_at, output int cyc);
    start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    chk("run2_t0_busy", {31'd0, busy2}, 32'd1);
    chk("run2_t0_done", {31'd0, done2}, 32'd0);
    chk("run2_t0_err",  {27'd0, err2}, 32'd0);
    chk("run2_t0_vec",  {28'd0, a2, b2}, 32'd0);
    chk("run2_t0_ffv",  {28'd0, ffv2}, 32'd0);
    chk("run2_t0_ffl",  {29'd0, ffl2}, 32'd0);
    cyc = 0;
    while (cyc < 1000) begin
      if (cyc == pulse_at) start2 = 1'b1;
      @(posedge clk); #1 start2 = 1'b0;
      cyc++;
      if (done2) break;
    end
    chk("run2_busy_end", {31'd0, busy2}, 32'd0);
  endtask

  task automatic run3(output int cyc);
    start3 = 1'b1;
    @(posedge clk); #1 start3 = 1'b0;
    chk("run3_t0_busy", {31'd0, busy3}, 32'd1);
    cyc = 0;
    while (cyc < 1000) begin
      @(posedge clk); #1;
      cyc++;
      if (done3) break;
    end
  endtask

  initial begin
    int cyc;
    int n;

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    chk_reset2("reset");
    chk("reset3_done", {31'd0, done3}, 32'd0);
    chk("reset3_err",  {25'd0, err3}, 32'd0);

    mode2 = 2'd0;
    run2(-1, cyc);
    chk("golden_cycles", cyc, 32'd48);
    chk("golden_pass",   {31'd0, pass2}, 32'd1);
    chk("golden_err",    {27'd0, err2}, 32'd0);
    chk("golden_ffv",    {28'd0, ffv2}, 32'd0);

    mode2 = 2'd1;
    run2(-1, cyc);
    chk("estuck_cycles", cyc, 32'd48);
    chk("estuck_err",    {27'd0, err2}, 32'd4);
    chk("estuck_pass",   {31'd0, pass2}, 32'd0);
    chk("estuck_ffv",    {28'd0, ffv2}, 32'd0);
    chk("estuck_ffl",    {29'd0, ffl2}, 32'd0);

    // Restart from DONE: run2 checks that results clear at T0.
    mode2 = 2'd2;
    run2(-1, cyc);
    chk("swap_cycles", cyc, 32'd48);
    chk("swap_err",    {27'd0, err2}, 32'd12);
    chk("swap_pass",   {31'd0, pass2}, 32'd0);
    chk("swap_ffv",    {28'd0, ffv2}, {28'd0, EXP_SWAP_VEC2});
    chk("swap_ffl",    {29'd0, ffl2}, {29'd0, EXP_SWAP_LEG});

    mode2 = 2'd0;
    run2(10, cyc);
    chk("busy_start_cycles", cyc, 32'd48);
    chk("busy_start_pass",   {31'd0, pass2}, 32'd1);

    start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    n = 0;
    while ({a2, b2} != 4'd5 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    chk("reach_vec5", {28'd0, a2, b2}, 32'd5);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    chk_reset2("midrun_rst");
    run2(-1, cyc);
    chk("after_rst_cycles", cyc, 32'd48);
    chk("after_rst_pass",   {31'd0, pass2}, 32'd1);

    mode3 = 2'd0;
    run3(cyc);
    chk("w3_golden_cycles", cyc, 32'd128);
    chk("w3_golden_pass",   {31'd0, pass3}, 32'd1);

    mode3 = 2'd2;
    run3(cyc);
    chk("w3_swap_err", {25'd0, err3}, 32'd56);
    chk("w3_swap_ffv", {26'd0, ffv3}, {26'd0, EXP_SWAP_VEC3});
    chk("w3_swap_ffl", {29'd0, ffl3}, {29'd0, EXP_SWAP_LEG});

    mode3 = 2'd1;
    run3(cyc);
    chk("w3_estuck_cycles", cyc, 32'd128);
    chk("w3_estuck_err",    {25'd0, err3}, 32'd8);
    chk("w3_estuck_pass",   {31'd0, pass3}, 32'd0);
    chk("w3_estuck_ffv",    {26'd0, ffv3}, 32'd0);
    chk("w3_estuck_ffl",    {29'd0, ffl3}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

`default_nettype wire
